asteroid_field: RTL and testbench
=================================

ASTEROID_FIELD -- requirements
Module: asteroid_field

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state updates on posedge CLK.
REQ-002 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-003 SHALL have port choice  input  4  latched spawn column from the upstream column-choice stage; 0-7 = column, 8-15 = no spawn.
REQ-004 SHALL have port tick  input  1  one-cycle step pulse marking one field advance.
REQ-005 SHALL have port start  input  1  level, sampled each cycle; requests a new game.
REQ-006 SHALL have port player  input  3  player column on bottom row (row 7).
REQ-007 SHALL have port row_sel  input  3  display row index for read-out.
REQ-008 SHALL have port row_data  output  8  combinational read of field row row_sel; bit c = asteroid in column c.
REQ-009 SHALL have port running  output  1  high in state RUN.
REQ-010 SHALL have port game_over  output  1  high in state OVER.
REQ-011 SHALL have port score  output  8  ticks survived in current game.

Function
REQ-012 SHALL hold an 8x8 field register, rows 0 (top) to 7 (bottom).
REQ-013 SHALL implement states IDLE, RUN, OVER, encoded in a registered state variable.
REQ-014 IDLE: start=1 -> clear field, clear score, go RUN next cycle; tick ignored.
REQ-015 RUN, collision=0, tick=1 -> row r <= row r-1 for r=1..7; row 0 <= one-hot(choice) if choice<8, else 8'h00; old row 7 discarded.
REQ-016 RUN, tick=1, choice>=8 SHALL insert an empty top row and still count the tick for score.
REQ-017 Collision SHALL be combinational: field[7][player] while in RUN, evaluated every cycle (covers asteroid arriving and player moving into an occupied cell).
REQ-018 RUN, collision=1 -> go OVER next cycle; field and score frozen; a simultaneous tick SHALL be ignored.
REQ-019 RUN, start=1 SHALL be ignored.
REQ-020 OVER: field and score held for display; tick ignored; start=1 -> clear field and score, go RUN next cycle.
REQ-021 Score SHALL increment by 1 on each tick accepted per REQ-015, updating in the same cycle as the shift.
REQ-022 Score SHALL saturate at 8'hFF; no wrap to zero.
REQ-023 Collision-to-game_over latency SHALL be exactly 1 cycle; tick-to-shift latency SHALL be 1 cycle (new field visible on row_data the cycle after tick).
REQ-024 running and game_over SHALL be registered decodes of state, never both high.
REQ-025 row_data SHALL reflect field contents only, independent of state.

Reset
REQ-026 RST=1 at posedge SHALL force state IDLE, field all zero, score 0, running 0, game_over 0.
REQ-027 RST SHALL take priority over start, tick and collision in the same cycle, including mid-game and in OVER.
REQ-028 Outputs SHALL be defined on the first posedge with RST=1; no asynchronous behaviour.

Configuration
REQ-029 Macro ASTEROID_SCORE_EN SHALL control the score counter.
REQ-030 With ASTEROID_SCORE_EN defined: score behaves per REQ-021/022.
REQ-031 Without ASTEROID_SCORE_EN: no score register synthesized; score SHALL be tied to 8'h00; all other behaviour unchanged.

Verification
REQ-032 Reset, start=1 one cycle -> running=1 next cycle, all rows 8'h00, score=0.
REQ-033 RUN, player=0, tick with choice=3 then 7 ticks with choice=8 -> bit 3 walks rows 0..7, no collision, score=8, row 7 = 8'h08; 9th tick clears it.
REQ-034 RUN, player=5, choice=5 then 7 ticks choice=15 -> row 7 = 8'h20, game_over=1 one cycle later, score=8 frozen; further ticks do not change field.
REQ-035 Asteroid resting in row 7 col 2, player moves 1->2 with no tick -> game_over=1 next cycle.
REQ-036 300 accepted ticks with no collision -> score saturates at 8'hFF (8'h00 with ASTEROID_SCORE_EN undefined).
REQ-037 RST=1 asserted in RUN coincident with tick and start -> IDLE, field zero, score 0 next cycle.

Source files
------------

// File: rtl/asteroid_field.sv
// asteroid_field: 8x8 falling-asteroid field with IDLE/RUN/OVER game FSM; score counter built only when ASTEROID_SCORE_EN is defined
module asteroid_field (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] choice,
  input  logic       tick,
  input  logic       start,
  input  logic [2:0] player,
  input  logic [2:0] row_sel,
  output logic [7:0] row_data,
  output logic       running,
  output logic       game_over,
  output logic [7:0] score
);
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  state_t state_q, state_d;
  logic [7:0][7:0] field_q, field_d;
  logic collision, shift_en, clear;
  logic [7:0] spawn;
  assign collision = (state_q == RUN) && field_q[7][player];
  assign shift_en  = (state_q == RUN) && !collision && tick;
  assign clear     = (state_q != RUN) && start;
  assign spawn     = choice[3] ? 8'h00 : 8'h01 << choice[2:0];
  // next state: a new game clears the field, a hit freezes it, an accepted tick drops every row by one
  always_comb begin
    state_d = clear ? RUN : collision ? OVER : state_q;
    field_d = clear ? '0 : shift_en ? {field_q[6:0], spawn} : field_q;
  end
  // state and field registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      field_q <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
    end
  end
  assign row_data  = field_q[row_sel];
  assign running   = state_q == RUN;
  assign game_over = state_q == OVER;
`ifdef ASTEROID_SCORE_EN
  logic [7:0] score_q, score_d;
  assign score_d = clear ? 8'h00 : (shift_en && score_q != 8'hFF) ? score_q + 8'd1 : score_q;
  // saturating count of ticks survived
  always_ff @(posedge CLK) begin
    if (RST) score_q <= 8'h00;
    else score_q <= score_d;
  end
  assign score = score_q;
`else
  assign score = 8'h00;
`endif
endmodule

// File: tb/tb_asteroid_field.sv
// tb_asteroid_field: scoreboard bench for asteroid_field against a queue-based game model
module tb_asteroid_field;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [3:0] choice = 4'd8;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic [2:0] player = 3'd0;
  logic [2:0] row_sel = 3'd0;
  logic [7:0] row_data;
  logic running, game_over;
  logic [7:0] score;

  asteroid_field dut (
    .CLK(CLK), .RST(RST), .choice(choice), .tick(tick), .start(start),
    .player(player), .row_sel(row_sel), .row_data(row_data),
    .running(running), .game_over(game_over), .score(score)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       run;
    logic       over;
    logic [7:0] sc;
    logic [2:0] rs;
    logic [7:0] row;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  int mode = 0;
  logic [7:0] mf[$];
  int msc = 0;

  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    mf.delete();
    repeat (8) mf.push_back(8'h00);
    msc = 0;
  endtask

  task automatic cyc(input logic r, input logic s, input logic t, input logic [3:0] ch,
                     input logic [2:0] pl, input logic [2:0] rs);
    exp_t e;
    logic [7:0] bottom;
    @(negedge CLK);
    #1;
    RST = r; start = s; tick = t; choice = ch; player = pl; row_sel = rs;
    bottom = mf[7];
    if (r) begin
      mode = 0;
      clear_model();
    end else if (mode != 1) begin
      if (s) begin
        mode = 1;
        clear_model();
      end
    end else if (bottom[pl]) begin
      mode = 2;
    end else if (t) begin
      mf.push_front(ch < 4'd8 ? 8'(1 << ch) : 8'h00);
      void'(mf.pop_back());
      if (msc < 255) msc++;
    end
    e.run  = (mode == 1);
    e.over = (mode == 2);
`ifdef ASTEROID_SCORE_EN
    e.sc = 8'(msc);
`else
    e.sc = 8'h00;
`endif
    e.rs  = rs;
    e.row = mf[rs];
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("running", {7'd0, running}, {7'd0, e.run});
        chk("game_over", {7'd0, game_over}, {7'd0, e.over});
        chk("score", score, e.sc);
        chk($sformatf("row_data[%0d]", e.rs), row_data, e.row);
      end
    end
  end

  initial begin
    clear_model();
    cyc(1, 0, 0, 8, 0, 0);
    cyc(1, 1, 1, 3, 0, 7);
    cyc(0, 1, 0, 8, 0, 0);
    cyc(0, 0, 0, 8, 0, 5);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, i == 0 ? 4'd3 : 4'd8, 0, 3'(i));
    cyc(0, 0, 1, 8, 0, 7);
    cyc(0, 0, 0, 8, 0, 7);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, i == 0 ? 4'd5 : 4'd15, 5, 7);
    cyc(0, 0, 1, 2, 5, 7);
    cyc(0, 1, 0, 8, 5, 7);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 5, 0);
    cyc(0, 1, 0, 8, 1, 7);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, i == 0 ? 4'd2 : 4'd8, 1, 7);
    cyc(0, 0, 0, 8, 1, 7);
    cyc(0, 0, 0, 8, 2, 7);
    cyc(0, 0, 1, 8, 2, 7);
    cyc(0, 1, 0, 8, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 4'(i), 7, 3'(i));
    cyc(1, 1, 1, 6, 7, 0);
    cyc(0, 0, 0, 8, 7, 1);
    cyc(0, 1, 0, 8, 0, 0);
    for (int i = 0; i < 300; i++) cyc(0, 0, 1, 8, 0, 3'(i));
    cyc(0, 0, 0, 8, 0, 7);
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] pl;
      pl = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : player;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
          4'($urandom_range(0, 15)), pl, 3'($urandom_range(0, 7)));
    end
    repeat (3) @(negedge CLK);
    #1;
    chk("scoreboard_drained", 8'(sb.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
